// File: rtl/proc_pkg.sv
// proc_pkg: shared opcode, ALU op, status and register constants for the pipeline
package proc_pkg;
  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_BNE   = 5'b00010;
  localparam logic [4:0] OP_JAL   = 5'b00011;
  localparam logic [4:0] OP_ADDI  = 5'b00101;
  localparam logic [4:0] OP_BLT   = 5'b00110;
  localparam logic [4:0] OP_SW    = 5'b00111;
  localparam logic [4:0] OP_LW    = 5'b01000;
  localparam logic [4:0] OP_SETX  = 5'b10101;
  localparam logic [4:0] ALU_ADD  = 5'b00000;
  localparam logic [4:0] ALU_SUB  = 5'b00001;
  localparam logic [31:0] RSTATUS_ADD  = 32'd1;
  localparam logic [31:0] RSTATUS_ADDI = 32'd2;
  localparam logic [31:0] RSTATUS_SUB  = 32'd3;
  localparam logic [4:0] REG_RSTATUS = 5'd30;
  localparam logic [4:0] REG_RA      = 5'd31;
  typedef enum logic [2:0] {
    SEL_ALU, SEL_PC1, SEL_T, SEL_ADD, SEL_ADDI, SEL_SUB
  } res_sel_e;
endpackage

// File: rtl/xm_decode.sv
// xm_decode: maps X-stage opcode fields and ALU flags to write-back, exception and branch control
module xm_decode
  import proc_pkg::*;
(
  input  logic [4:0] op_i,
  input  logic [4:0] rd_i,
  input  logic [4:0] aluop_i,
  input  logic       ovf_i,
  input  logic       ne_i,
  input  logic       lt_i,
  output logic [4:0] rd_o,
  output logic       we_o,
  output logic       exc_o,
  output logic       br_taken_o,
  output res_sel_e   sel_o
);
  logic exc_add, exc_addi, exc_sub;
  // Overflow only matters for add, addi and sub; it redirects the write to $rstatus
  always_comb begin
    exc_add    = op_i == OP_RTYPE && aluop_i == ALU_ADD && ovf_i;
    exc_addi   = op_i == OP_ADDI && ovf_i;
    exc_sub    = op_i == OP_RTYPE && aluop_i == ALU_SUB && ovf_i;
    exc_o      = exc_add | exc_addi | exc_sub;
    we_o       = exc_o | op_i == OP_RTYPE | op_i == OP_ADDI | op_i == OP_LW | op_i == OP_JAL | op_i == OP_SETX;
    rd_o       = (exc_o || op_i == OP_SETX) ? REG_RSTATUS : op_i == OP_JAL ? REG_RA : rd_i;
    sel_o      = exc_add ? SEL_ADD : exc_addi ? SEL_ADDI : exc_sub ? SEL_SUB :
                 op_i == OP_JAL ? SEL_PC1 : op_i == OP_SETX ? SEL_T : SEL_ALU;
    br_taken_o = (op_i == OP_BNE && ne_i) || (op_i == OP_BLT && lt_i);
  end
endmodule

// File: rtl/xm_stage.sv
// xm_stage: execute/memory pipeline register with exception resolution and exception counter
module xm_stage
  import proc_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             x_valid,
  input  logic [31:0]      x_instr,
  input  logic [31:0]      x_pc1,
  input  logic [31:0]      x_result,
  input  logic [31:0]      x_dataB,
  input  logic             x_ovf,
  input  logic             x_ne,
  input  logic             x_lt,
  input  logic             stall,
  input  logic             flush,
  output logic             m_valid,
  output logic [31:0]      m_instr,
  output logic [31:0]      m_result,
  output logic [31:0]      m_dataB,
  output logic [4:0]       m_rd,
  output logic             m_we,
  output logic             m_br_taken,
  output logic             m_exc,
  output logic [CNT_W-1:0] exc_count
);
  logic [4:0]       dec_rd, rd_q, rd_d;
  logic             dec_we, dec_exc, dec_br, load;
  res_sel_e         dec_sel;
  logic [31:0]      res, instr_q, instr_d, result_q, result_d, data_b_q, data_b_d;
  logic             valid_q, valid_d, we_q, we_d, exc_q, exc_d, br_q, br_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  xm_decode u_decode (
    .op_i       (x_instr[31:27]),
    .rd_i       (x_instr[26:22]),
    .aluop_i    (x_instr[6:2]),
    .ovf_i      (x_ovf),
    .ne_i       (x_ne),
    .lt_i       (x_lt),
    .rd_o       (dec_rd),
    .we_o       (dec_we),
    .exc_o      (dec_exc),
    .br_taken_o (dec_br),
    .sel_o      (dec_sel)
  );

  assign load = !flush && !stall;

  // Result mux: ALU value, link address, zero-extended target, or an $rstatus code
  always_comb begin
    res = dec_sel == SEL_PC1  ? x_pc1 :
          dec_sel == SEL_T    ? {5'd0, x_instr[26:0]} :
          dec_sel == SEL_ADD  ? RSTATUS_ADD :
          dec_sel == SEL_ADDI ? RSTATUS_ADDI :
          dec_sel == SEL_SUB  ? RSTATUS_SUB : x_result;
  end

  // Next state: flush loads a bubble and beats stall; data registers simply hold unless loading
  always_comb begin
    valid_d  = flush ? 1'b0 : stall ? valid_q : x_valid;
    instr_d  = flush ? '0 : stall ? instr_q : x_instr;
    we_d     = flush ? 1'b0 : stall ? we_q : x_valid & dec_we;
    exc_d    = flush ? 1'b0 : stall ? exc_q : x_valid & dec_exc;
    br_d     = flush ? 1'b0 : stall ? br_q : x_valid & dec_br;
    rd_d     = load ? dec_rd : rd_q;
    result_d = load ? res : result_q;
    data_b_d = load ? x_dataB : data_b_q;
    cnt_d    = (load && x_valid && dec_exc && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
  end

  // Pipeline registers and counter, cleared asynchronously
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q  <= 1'b0;
      instr_q  <= '0;
      we_q     <= 1'b0;
      exc_q    <= 1'b0;
      br_q     <= 1'b0;
      rd_q     <= '0;
      result_q <= '0;
      data_b_q <= '0;
      cnt_q    <= '0;
    end else begin
      valid_q  <= valid_d;
      instr_q  <= instr_d;
      we_q     <= we_d;
      exc_q    <= exc_d;
      br_q     <= br_d;
      rd_q     <= rd_d;
      result_q <= result_d;
      data_b_q <= data_b_d;
      cnt_q    <= cnt_d;
    end
  end

  assign m_valid    = valid_q;
  assign m_instr    = instr_q;
  assign m_result   = result_q;
  assign m_dataB    = data_b_q;
  assign m_rd       = rd_q;
  assign m_we       = we_q;
  assign m_br_taken = br_q;
  assign m_exc      = exc_q;
  assign exc_count  = cnt_q;
endmodule
